// File: rtl/audio_mux_pkg.sv
// rtl/audio_mux_pkg.sv - shared constants, types and helpers for audio_mux_mc
//
// Purpose : register offsets (added to NUM_CH), fill FSM state encoding,
//           recognised sample rates and the SRATE -> sr_mode decode.
// Ports   : none (package).
package audio_mux_pkg;

  localparam int CTRL_OFS    = 0;
  localparam int BUFSIZE_OFS = 1;
  localparam int SRATE_OFS   = 2;
  localparam int STATUS_OFS  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } fill_state_e;

  localparam logic [31:0] SR_44100 = 32'd44100;
  localparam logic [31:0] SR_48000 = 32'd48000;
  localparam logic [31:0] SR_96000 = 32'd96000;

  localparam logic [1:0] SR_MODE_44    = 2'd0;
  localparam logic [1:0] SR_MODE_48    = 2'd1;
  localparam logic [1:0] SR_MODE_96    = 2'd2;
  localparam logic [1:0] SR_MODE_OTHER = 2'd3;

  function automatic logic [1:0] sr_decode(input logic [31:0] rate);
    logic [1:0] mode;
    case (rate)
      SR_44100: mode = SR_MODE_44;
      SR_48000: mode = SR_MODE_48;
      SR_96000: mode = SR_MODE_96;
      default:  mode = SR_MODE_OTHER;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/audio_fill_fsm.sv
// rtl/audio_fill_fsm.sv - buffered-fill state machine, fill counter and underrun flag
//
// Purpose : counts synth cycles (xxxx_top while the engine is idle) into the
//           JACK buffer, reports FULL, restarts on each JACK cycle end and
//           flags an underrun when a JACK cycle ends before the buffer filled.
//           Also selects the sample trigger source.
// Ports   : clk, reset        - clock, async active-high reset
//           buffersize        - fill target; 0 selects I2S-locked mode (IDLE)
//           xxxx_top, run     - synth cycle-top pulse and engine-busy level
//           jack_cycle_end    - single-cycle end-of-JACK-read pulse
//           lrck_rise         - synchronised I2S word-clock rising edge
//           clr_underrun      - STATUS write strobe
//           state, counter    - current FSM state and fill count
//           underrun          - sticky underrun flag
//           trig              - one-cycle sample trigger
module audio_fill_fsm
  import audio_mux_pkg::*;
#(
  parameter int FIFO_WIDTH = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FIFO_WIDTH:0] buffersize,
  input  logic                xxxx_top,
  input  logic                run,
  input  logic                jack_cycle_end,
  input  logic                lrck_rise,
  input  logic                clr_underrun,
  output fill_state_e         state,
  output logic [FIFO_WIDTH:0] counter,
  output logic                underrun,
  output logic                trig
);

  localparam logic [FIFO_WIDTH:0] ONE = {{FIFO_WIDTH{1'b0}}, 1'b1};

  fill_state_e         r_state;
  logic [FIFO_WIDTH:0] r_counter;
  logic                r_underrun;
  logic                r_run_trig;

  logic w_bs_zero;
  logic w_final_trig;
  logic w_underrun_set;

  always_comb begin
    w_bs_zero    = (buffersize == '0);
    // The run_trig that brings the count up to buffersize.
    w_final_trig = r_run_trig && (r_counter == buffersize - ONE);
    // A JACK cycle ending mid-fill is an underrun, unless the final
    // increment lands on the same clock (the increment wins).
    w_underrun_set = (r_state == FILL) && !w_bs_zero && (r_counter < buffersize) &&
                     jack_cycle_end && !w_final_trig;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_counter  <= '0;
      r_underrun <= 1'b0;
      r_run_trig <= 1'b0;
    end else begin
      // Only FILL listens to the synth; FULL and IDLE ignore xxxx_top.
      r_run_trig <= (r_state == FILL) && xxxx_top && !run;

      // Set has priority over a coincident STATUS clear.
      r_underrun <= w_underrun_set || (r_underrun && !clr_underrun);

      if (w_bs_zero) begin
        r_state   <= IDLE;
        r_counter <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state   <= FILL;
            r_counter <= '0;
          end
          FILL: begin
            if (r_counter >= buffersize) begin
              // buffersize was rewritten at or below the count: clamp and stop.
              r_state   <= FULL;
              r_counter <= buffersize;
            end else if (w_final_trig) begin
              r_state   <= FULL;
              r_counter <= buffersize;
            end else if (jack_cycle_end) begin
              r_counter <= '0;
            end else if (r_run_trig) begin
              r_counter <= r_counter + ONE;
            end
          end
          FULL: begin
            if (jack_cycle_end) begin
              r_state   <= FILL;
              r_counter <= '0;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_counter <= '0;
          end
        endcase
      end
    end
  end

  assign state    = r_state;
  assign counter  = r_counter;
  assign underrun = r_underrun;
  assign trig     = (r_state == IDLE) ? lrck_rise : r_run_trig;

endmodule

// File: rtl/audio_mux_mc.sv
// rtl/audio_mux_mc.sv - multichannel JACK/I2S audio mux with register bus
//
// Purpose : serves NUM_CH sample registers plus CTRL/BUFSIZE/SRATE/STATUS
//           over a 32-bit register bus, synchronises the I2S word clock and
//           produces the sample trigger (I2S-locked or buffered fill).
// Ports   : clk, reset                  - clock, async active-high reset
//           address, read, write, datain - register bus request
//           dataout                      - registered read data
//           ch_read                      - per-channel read strobes
//           sound_in                     - packed channel samples, ch k at k*AUD_BIT_DEPTH
//           xxxx_top, run                - synth cycle-top pulse, engine busy
//           lrck                         - asynchronous I2S word clock
//           trig                         - one-cycle sample trigger
//           i2s_enable, fill_active      - mode / FSM-in-FILL indicators
//           underrun                     - sticky underrun flag
//           sr_mode, samplerate_is_48    - decoded sample rate
module audio_mux_mc
  import audio_mux_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int AUD_BIT_DEPTH = 24,
  parameter int FIFO_WIDTH    = 6,
  parameter int ADDR_WIDTH    = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic                            read,
  input  logic                            write,
  input  logic [31:0]                     datain,
  input  logic [NUM_CH*AUD_BIT_DEPTH-1:0] sound_in,
  input  logic                            xxxx_top,
  input  logic                            lrck,
  input  logic                            run,
  output logic [31:0]                     dataout,
  output logic [NUM_CH-1:0]               ch_read,
  output logic                            trig,
  output logic                            i2s_enable,
  output logic                            fill_active,
  output logic                            underrun,
  output logic [1:0]                      sr_mode,
  output logic                            samplerate_is_48
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(NUM_CH + CTRL_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BUFSIZE = ADDR_WIDTH'(NUM_CH + BUFSIZE_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SRATE   = ADDR_WIDTH'(NUM_CH + SRATE_OFS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'(NUM_CH + STATUS_OFS);

  logic [31:0]         r_dataout;
  logic                r_jack_read_act;
  logic                r_jack_prev;
  logic                r_jack_cycle_end;
  logic [FIFO_WIDTH:0] r_buffersize;
  logic [31:0]         r_samplerate;
  logic [1:0]          r_sr_mode;
  logic                r_lrck_meta;
  logic                r_lrck_sync;
  logic                r_lrck_prev;
  logic                r_lrck_rise;

  logic [NUM_CH-1:0]        w_ch_read;
  logic [AUD_BIT_DEPTH-1:0] w_sample;
  logic                     w_sample_hit;
  logic [31:0]              w_rdata;
  logic                     w_status_wr;
  fill_state_e              w_state;
  logic [FIFO_WIDTH:0]      w_counter;
  logic                     w_underrun;
  logic                     w_trig;

  // Sample channel decode: read strobes and the addressed sample.
  always_comb begin
    w_ch_read    = '0;
    w_sample     = '0;
    w_sample_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (address == ADDR_WIDTH'(k)) begin
        w_ch_read[k] = read;
        w_sample     = sound_in[k*AUD_BIT_DEPTH +: AUD_BIT_DEPTH];
        w_sample_hit = 1'b1;
      end
    end
  end

  // Read mux; samples are left-justified in the 32-bit word.
  always_comb begin
    w_rdata = '0;
    if (w_sample_hit) begin
      w_rdata[31 -: AUD_BIT_DEPTH] = w_sample;
    end else begin
      case (address)
        ADDR_CTRL:    w_rdata[0]            = r_jack_read_act;
        ADDR_BUFSIZE: w_rdata[FIFO_WIDTH:0] = r_buffersize;
        ADDR_SRATE:   w_rdata               = r_samplerate;
        ADDR_STATUS: begin
          w_rdata[0]                = w_underrun;
          w_rdata[2:1]              = w_state;
          w_rdata[3 +: FIFO_WIDTH+1] = w_counter;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  assign w_status_wr = write && (address == ADDR_STATUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataout       <= '0;
      r_jack_read_act <= 1'b0;
      r_buffersize    <= '0;
      r_samplerate    <= SR_48000;
      r_sr_mode       <= SR_MODE_48;
    end else begin
      if (read) begin
        r_dataout <= w_rdata;
      end
      if (write) begin
        case (address)
          ADDR_CTRL:    r_jack_read_act <= datain[0];
          ADDR_BUFSIZE: r_buffersize    <= datain[FIFO_WIDTH:0];
          ADDR_SRATE:   r_samplerate    <= datain;
          default: ;
        endcase
      end
      r_sr_mode <= sr_decode(r_samplerate);
    end
  end

  // JACK cycle end: falling edge of jack_read_act, one register late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_jack_prev      <= 1'b0;
      r_jack_cycle_end <= 1'b0;
    end else begin
      r_jack_prev      <= r_jack_read_act;
      r_jack_cycle_end <= r_jack_prev && !r_jack_read_act;
    end
  end

  // lrck: two-flop synchroniser, then a registered rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lrck_meta <= 1'b0;
      r_lrck_sync <= 1'b0;
      r_lrck_prev <= 1'b0;
      r_lrck_rise <= 1'b0;
    end else begin
      r_lrck_meta <= lrck;
      r_lrck_sync <= r_lrck_meta;
      r_lrck_prev <= r_lrck_sync;
      r_lrck_rise <= r_lrck_sync && !r_lrck_prev;
    end
  end

  audio_fill_fsm #(
    .FIFO_WIDTH(FIFO_WIDTH)
  ) u_fill_fsm (
    .clk           (clk),
    .reset         (reset),
    .buffersize    (r_buffersize),
    .xxxx_top      (xxxx_top),
    .run           (run),
    .jack_cycle_end(r_jack_cycle_end),
    .lrck_rise     (r_lrck_rise),
    .clr_underrun  (w_status_wr),
    .state         (w_state),
    .counter       (w_counter),
    .underrun      (w_underrun),
    .trig          (w_trig)
  );

  assign dataout          = r_dataout;
  assign ch_read          = w_ch_read;
  assign trig             = w_trig;
  assign i2s_enable       = (r_buffersize == '0);
  assign fill_active      = (w_state == FILL);
  assign underrun         = w_underrun;
  assign sr_mode          = r_sr_mode;
  assign samplerate_is_48 = (r_sr_mode == SR_MODE_48);

endmodule

// File: tb/tb_audio_mux_mc.sv
// tb/tb_audio_mux_mc.sv - self-checking bench for audio_mux_mc
module tb_audio_mux_mc;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   address;
  logic         read;
  logic         write;
  logic [31:0]  datain;
  logic [191:0] sound_in;
  logic         xxxx_top;
  logic         lrck;
  logic         run;
  logic [31:0]  dataout;
  logic [7:0]   ch_read;
  logic         trig;
  logic         i2s_enable;
  logic         fill_active;
  logic         underrun;
  logic [1:0]   sr_mode;
  logic         samplerate_is_48;

  int checks = 0;
  int errors = 0;
  int trig_count = 0;

  audio_mux_mc dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .read            (read),
    .write           (write),
    .datain          (datain),
    .sound_in        (sound_in),
    .xxxx_top        (xxxx_top),
    .lrck            (lrck),
    .run             (run),
    .dataout         (dataout),
    .ch_read         (ch_read),
    .trig            (trig),
    .i2s_enable      (i2s_enable),
    .fill_active     (fill_active),
    .underrun        (underrun),
    .sr_mode         (sr_mode),
    .samplerate_is_48(samplerate_is_48)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  m_bufsize;
  logic        m_jack;
  logic [31:0] m_srate;
  logic [1:0]  m_sr_mode;
  logic [31:0] m_dout;
  logic        m_dout_known;
  logic [3:0]  m_hist;   // lrck seen at the last four clock edges, [0] newest
  int          m_zero;   // edges seen with buffersize == 0 (trigger is lrck-locked)

  function automatic logic [1:0] rate_mode(input logic [31:0] r);
    if (r == 32'd44100) return 2'd0;
    if (r == 32'd48000) return 2'd1;
    if (r == 32'd96000) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai < 8) return {sound_in[ai*24 +: 24], 8'h00};
    if (ai == 8) return {31'd0, m_jack};
    if (ai == 9) return {25'd0, m_bufsize};
    if (ai == 10) return m_srate;
    return 32'd0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_bufsize    <= '0;
      m_jack       <= 1'b0;
      m_srate      <= 32'd48000;
      m_sr_mode    <= 2'd1;
      m_dout       <= '0;
      m_dout_known <= 1'b1;
      m_hist       <= '0;
      m_zero       <= 1;
    end else begin
      if (read) begin
        m_dout       <= exp_read(address);
        m_dout_known <= (address != 5'd11);
      end
      if (write) begin
        if (address == 5'd8)  m_jack    <= datain[0];
        if (address == 5'd9)  m_bufsize <= datain[6:0];
        if (address == 5'd10) m_srate   <= datain;
      end
      m_sr_mode <= rate_mode(m_srate);
      m_hist    <= {m_hist[2:0], lrck};
      if (m_bufsize == 7'd0) m_zero <= (m_zero < 100) ? m_zero + 1 : m_zero;
      else m_zero <= 0;
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    logic [7:0] e_ch;
    if (!reset) begin
      e_ch = '0;
      if (read && address < 5'd8) e_ch[address[2:0]] = 1'b1;
      chk("ch_read", {24'd0, ch_read}, {24'd0, e_ch});
      if (m_dout_known) chk("dataout", dataout, m_dout);
      chk("i2s_enable", {31'd0, i2s_enable}, {31'd0, m_bufsize == 7'd0});
      chk("sr_mode", {30'd0, sr_mode}, {30'd0, m_sr_mode});
      chk("samplerate_is_48", {31'd0, samplerate_is_48}, {31'd0, m_sr_mode == 2'd1});
      // In lrck-locked mode the trigger follows an lrck rise by three edges.
      if (m_zero >= 1) chk("trig_i2s", {31'd0, trig}, {31'd0, m_hist[2] & ~m_hist[3]});
      if (trig) trig_count++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    write = 1'b1; address = a; datain = d;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    read = 1'b1; address = a;
    @(posedge clk); #1;
    read = 1'b0;
    d = dataout;
  endtask

  task automatic pulse_top();
    @(posedge clk); #1;
    xxxx_top = 1'b1;
    @(posedge clk); #1;
    xxxx_top = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(5'd11, d);
    chk(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic [23:0] s;
    int          n;
    int          base;
    logic [31:0] rates [4];
    logic [1:0]  modes [4];

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; datain = '0;
    xxxx_top = 1'b0; lrck = 1'b0; run = 1'b0;
    for (int k = 0; k < 8; k++) sound_in[k*24 +: 24] = 24'h100000 + 24'(k);

    repeat (3) @(posedge clk); #1;
    chk("rst_dataout", dataout, 32'd0);
    chk("rst_trig", {31'd0, trig}, 32'd0);
    chk("rst_sr_mode", {30'd0, sr_mode}, 32'd1);
    chk("rst_is48", {31'd0, samplerate_is_48}, 32'd1);
    chk("rst_i2s_enable", {31'd0, i2s_enable}, 32'd1);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_fill_active", {31'd0, fill_active}, 32'd0);
    reset = 1'b0;

    // Sample reads, left-justified, with one-hot strobes.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      read = 1'b1; address = 5'(k);
      #1 chk("ch_read_onehot", {24'd0, ch_read}, 32'd1 << k);
      @(posedge clk); #1;
      read = 1'b0;
      s = 24'h100000 + 24'(k);
      chk("sample_read", dataout, {s, 8'h00});
    end
    bus_read(5'd13, d);
    chk("unmapped_read", d, 32'd0);

    // I2S-locked mode: latency of the first trigger.
    @(posedge clk); #1;
    lrck = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk); n++;
      #1;
      if (trig) break;
    end
    chk("i2s_latency", n, 32'd3);
    chk("i2s_enable_on", {31'd0, i2s_enable}, 32'd1);
    repeat (8) @(posedge clk); #1 lrck = 1'b0;
    repeat (10) @(posedge clk);
    base = trig_count;
    for (int p = 0; p < 4; p++) begin
      #1 lrck = 1'b1;
      repeat (10) @(posedge clk);
      #1 lrck = 1'b0;
      repeat (10) @(posedge clk);
    end
    chk("i2s_trig_count", trig_count - base, 32'd4);

    // Buffered fill to FULL.
    bus_write(5'd8, 32'd1);
    bus_write(5'd9, 32'd4);
    repeat (2) @(posedge clk); #1;
    chk("fill_active_on", {31'd0, fill_active}, 32'd1);
    chk("i2s_enable_off", {31'd0, i2s_enable}, 32'd0);
    base = trig_count;
    pulse_top();
    read_status("status_cnt1", 32'd10);
    repeat (3) pulse_top();
    chk("fill_trig_count", trig_count - base, 32'd4);
    read_status("status_full", 32'd36);
    #1 chk("fill_active_full", {31'd0, fill_active}, 32'd0);
    pulse_top();
    chk("full_ignores_top", trig_count - base, 32'd4);
    read_status("status_full_hold", 32'd36);
    bus_write(5'd8, 32'd0);
    repeat (4) @(posedge clk);
    read_status("status_refill", 32'd2);
    #1 chk("fill_active_refill", {31'd0, fill_active}, 32'd1);

    // Underrun: JACK cycle ends at count 2 of 4.
    bus_write(5'd8, 32'd1);
    repeat (2) pulse_top();
    read_status("status_cnt2", 32'd18);
    bus_write(5'd8, 32'd0);
    repeat (4) @(posedge clk);
    read_status("status_underrun", 32'd3);
    #1 chk("underrun_set", {31'd0, underrun}, 32'd1);
    bus_write(5'd11, 32'd0);
    #1 chk("underrun_clr", {31'd0, underrun}, 32'd0);
    read_status("status_after_clr", 32'd2);

    // Engine busy: top pulse is ignored.
    base = trig_count;
    run = 1'b1;
    pulse_top();
    run = 1'b0;
    chk("run_blocks_trig", trig_count - base, 32'd0);
    read_status("status_run", 32'd2);

    // Asynchronous reset while a fill trigger is high.
    repeat (2) pulse_top();
    read_status("status_pre_rst", 32'd18);
    @(posedge clk); #1 xxxx_top = 1'b1;
    @(posedge clk); #1 xxxx_top = 1'b0;
    chk("trig_before_rst", {31'd0, trig}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_trig", {31'd0, trig}, 32'd0);
    chk("rst_mid_fill", {31'd0, fill_active}, 32'd0);
    chk("rst_mid_i2s", {31'd0, i2s_enable}, 32'd1);
    chk("rst_mid_dataout", dataout, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    read_status("status_post_rst", 32'd0);
    bus_read(5'd9, d);
    chk("bufsize_post_rst", d, 32'd0);
    bus_read(5'd10, d);
    chk("srate_post_rst", d, 32'd48000);

    // Sample-rate decode.
    rates[0] = 32'd44100; modes[0] = 2'd0;
    rates[1] = 32'd48000; modes[1] = 2'd1;
    rates[2] = 32'd96000; modes[2] = 2'd2;
    rates[3] = 32'd22050; modes[3] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      bus_write(5'd10, rates[i]);
      repeat (2) @(posedge clk); #1;
      chk("sr_mode_lit", {30'd0, sr_mode}, {30'd0, modes[i]});
      chk("is48_lit", {31'd0, samplerate_is_48}, {31'd0, i == 1});
      bus_read(5'd10, d);
      chk("srate_readback", d, rates[i]);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
